// File: rtl/rr_pkg.sv
// Shared grant-code definitions for the round-robin arbiter and its downstream burst mux.
// Holds the GRANT encoding, a decode helper and the burst-mux state encoding.
package rr_pkg;

  localparam logic [3:0] G_NONE = 4'd0;
  localparam logic [3:0] G_R0   = 4'd1;
  localparam logic [3:0] G_R1   = 4'd2;
  localparam logic [3:0] G_R2   = 4'd3;
  localparam logic [3:0] G_R3   = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } grant_dec_t;

  // G_NONE and codes 5..15 both decode as not legal; callers tell them apart.
  function automatic grant_dec_t grant_to_idx(input logic [3:0] code);
    grant_dec_t dec;
    dec.legal = 1'b0;
    dec.idx   = 2'd0;
    case (code)
      G_R0:    begin dec.legal = 1'b1; dec.idx = 2'd0; end
      G_R1:    begin dec.legal = 1'b1; dec.idx = 2'd1; end
      G_R2:    begin dec.legal = 1'b1; dec.idx = 2'd2; end
      G_R3:    begin dec.legal = 1'b1; dec.idx = 2'd3; end
      default: begin dec.legal = 1'b0; dec.idx = 2'd0; end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/grant_burst_mux_beat_counter.sv
// Beat counter for one granted burst: cleared on lock, advanced per accepted beat.
// Width is sized so BURST_LEN-1 always fits and the count never wraps within a burst.
module beat_counter #(
  parameter int BURST_LEN = 4,
  parameter int CW        = $clog2(BURST_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          is_last
);

  // Count register: reset and clear dominate the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign is_last = (count == CW'(BURST_LEN - 1));

endmodule

// File: rtl/grant_burst_mux.sv
// Locks the arbiter's winner and moves a BURST_LEN-beat burst from it to one shared
// valid/ready output port, then pulses a one-cycle release back to that requester.
module grant_burst_mux
  import rr_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            RST,
  input  logic [3:0]      GRANT,
  input  logic [4*DW-1:0] DATA_IN,
  input  logic [3:0]      VALID_IN,
  output logic [3:0]      READY_IN,
  output logic [DW-1:0]   OUT_DATA,
  output logic            OUT_VALID,
  output logic            OUT_LAST,
  input  logic            OUT_READY,
  output logic [1:0]      OWNER,
  output logic            BUSY,
  output logic [3:0]      REL,
  output logic            ERR
);

  localparam int CW = $clog2(BURST_LEN + 1);

  state_t        state;
  grant_dec_t    gdec;
  logic [CW-1:0] count;
  logic          is_last;
  logic          cnt_clr;
  logic          fire;

  assign gdec    = grant_to_idx(GRANT);
  assign cnt_clr = (state == ST_IDLE) && gdec.legal;
  assign fire    = OUT_VALID && OUT_READY;

  beat_counter #(
    .BURST_LEN (BURST_LEN),
    .CW        (CW)
  ) u_beat_counter (
    .clk     (clk),
    .rst     (RST),
    .clr     (cnt_clr),
    .inc     (fire),
    .count   (count),
    .is_last (is_last)
  );

  // Owner data path: only live in XFER; the owner stays steered even with VALID low.
  always_comb begin
    OUT_DATA  = '0;
    OUT_VALID = 1'b0;
    OUT_LAST  = 1'b0;
    READY_IN  = 4'b0000;
    if (state == ST_XFER) begin
      OUT_DATA        = DATA_IN[OWNER*DW +: DW];
      OUT_VALID       = VALID_IN[OWNER];
      OUT_LAST        = VALID_IN[OWNER] && is_last;
      READY_IN[OWNER] = OUT_READY;
    end else begin
      OUT_DATA  = '0;
      OUT_VALID = 1'b0;
      OUT_LAST  = 1'b0;
      READY_IN  = 4'b0000;
    end
  end

  // Burst control FSM; GRANT is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= ST_IDLE;
      OWNER <= 2'd0;
      BUSY  <= 1'b0;
      REL   <= 4'b0000;
      ERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          REL <= 4'b0000;
          if (gdec.legal) begin
            OWNER <= gdec.idx;
            BUSY  <= 1'b1;
            state <= ST_LOCK;
          end else if (GRANT != G_NONE) begin
            ERR <= 1'b1;
          end
        end
        ST_LOCK: begin
          state <= ST_XFER;
        end
        ST_XFER: begin
          if (fire && is_last) begin
            BUSY  <= 1'b0;
            REL   <= 4'b0001 << OWNER;
            state <= ST_REL;
          end
        end
        ST_REL: begin
          REL   <= 4'b0000;
          state <= ST_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          REL   <= 4'b0000;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
